// File: rtl/lcd1602_bus_monitor.sv
// Receive side of an HD44780/LCD1602 8-bit parallel bus: captures transfers on
// the falling edge of enable, decodes commands and keeps a DDRAM shadow.
module lcd1602_bus_monitor #(
  parameter int DATA_BITS    = 8,
  parameter int LINE_LEN     = 40,
  parameter int VISIBLE_COLS = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            lcd_rs,
  input  logic                            lcd_rw,
  input  logic                            lcd_enable,
  input  logic [DATA_BITS-1:0]            lcd_data,
  input  logic                            rd_line,
  input  logic [$clog2(VISIBLE_COLS)-1:0] rd_col,
  output logic [DATA_BITS-1:0]            rd_char,
  output logic [6:0]                      addr_ctr,
  output logic                            busy,
  output logic                            cmd_strobe,
  output logic                            data_strobe,
  output logic [DATA_BITS-1:0]            last_byte,
  output logic                            disp_on,
  output logic                            cursor_on,
  output logic                            blink_on,
  output logic                            incr_mode,
  output logic                            two_line,
  output logic                            overrun,
  output logic                            rw_error
);

  // state  | meaning
  // IDLE   | waiting for an enable falling edge
  // DECODE | one cycle: execute the captured command or data write
  // CLEAR  | writing 0x20 to every DDRAM byte, one per cycle
  typedef enum logic [1:0] {IDLE, DECODE, CLEAR} state_t;

  localparam int         DEPTH      = 2 * LINE_LEN;
  localparam int         COL_W      = $clog2(VISIBLE_COLS);
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LAST0      = 7'(LINE_LEN - 1);
  localparam logic [6:0] LAST1      = 7'(64 + LINE_LEN - 1);
  localparam logic [6:0] LAST_IDX   = 7'(DEPTH - 1);
  localparam logic [6:0] LINE_LEN7  = 7'(LINE_LEN);

  logic [SYNC_STAGES-1:0] rs_sync_q, rw_sync_q, en_sync_q;
  logic [DATA_BITS-1:0]   data_sync_q [SYNC_STAGES];
  logic                   en_prev_q;
  logic                   rs_s, rw_s, en_s, fall;
  logic [DATA_BITS-1:0]   data_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_sync_q <= '0;
      rw_sync_q <= '0;
      en_sync_q <= '0;
      en_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
    end else begin
      rs_sync_q      <= {rs_sync_q[SYNC_STAGES-2:0], lcd_rs};
      rw_sync_q      <= {rw_sync_q[SYNC_STAGES-2:0], lcd_rw};
      en_sync_q      <= {en_sync_q[SYNC_STAGES-2:0], lcd_enable};
      en_prev_q      <= en_s;
      data_sync_q[0] <= lcd_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  assign rs_s   = rs_sync_q[SYNC_STAGES-1];
  assign rw_s   = rw_sync_q[SYNC_STAGES-1];
  assign en_s   = en_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = en_prev_q & ~en_s;

  state_t               state_q, state_d;
  logic [6:0]           clr_cnt_q, clr_cnt_d, ac_q, ac_d, ac_idx, ac_step;
  logic                 cap_rs_q, cap_rs_d;
  logic [DATA_BITS-1:0] cap_data_q, cap_data_d, last_q, last_d;
  logic                 disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
  logic                 incr_q, incr_d, two_line_q, two_line_d, rw_err_q, rw_err_d;
  logic                 we;
  logic [6:0]           wa;
  logic [DATA_BITS-1:0] wd;

  // Two-line mode packs line 1 (0x40..) directly after line 0 in the array.
  always_comb begin
    if (!two_line_q)  ac_idx = ac_q;
    else if (ac_q[6]) ac_idx = LINE_LEN7 + {1'b0, ac_q[5:0]};
    else              ac_idx = {1'b0, ac_q[5:0]};
  end

  always_comb begin
    ac_step = ac_q;
    if (two_line_q) begin
      if (incr_q) begin
        if (ac_q == LAST0)      ac_step = LINE1_BASE;
        else if (ac_q == LAST1) ac_step = 7'h00;
        else                    ac_step = ac_q + 7'd1;
      end else begin
        if (ac_q == LINE1_BASE) ac_step = LAST0;
        else if (ac_q == 7'h00) ac_step = LAST1;
        else                    ac_step = ac_q - 7'd1;
      end
    end else if (incr_q) begin
      ac_step = (ac_q >= LAST_IDX) ? 7'h00 : ac_q + 7'd1;
    end else begin
      ac_step = (ac_q == 7'h00 || ac_q > LAST_IDX) ? LAST_IDX : ac_q - 7'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    ac_d        = ac_q;
    cap_rs_d    = cap_rs_q;
    cap_data_d  = cap_data_q;
    last_d      = last_q;
    disp_d      = disp_q;
    cursor_d    = cursor_q;
    blink_d     = blink_q;
    incr_d      = incr_q;
    two_line_d  = two_line_q;
    rw_err_d    = rw_err_q | (fall & rw_s);
    we          = 1'b0;
    wa          = clr_cnt_q;
    wd          = DATA_BITS'(8'h20);
    cmd_strobe  = 1'b0;
    data_strobe = 1'b0;
    overrun     = fall && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (fall && !rw_s) begin
          cap_rs_d   = rs_s;
          cap_data_d = data_s;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        last_d  = cap_data_q;
        if (cap_rs_q) begin
          we          = 1'b1;
          wa          = ac_idx;
          wd          = cap_data_q;
          data_strobe = 1'b1;
          ac_d        = ac_step;
        end else begin
          cmd_strobe = 1'b1;
          if (cap_data_q[7]) begin
            if (!cap_data_q[6] && cap_data_q[6:0] > LAST0)     ac_d = LINE1_BASE;
            else if (cap_data_q[6] && cap_data_q[6:0] > LAST1) ac_d = 7'h00;
            else                                               ac_d = cap_data_q[6:0];
          end else if (cap_data_q[6]) begin
          end else if (cap_data_q[5]) begin
            two_line_d = cap_data_q[3];
          end else if (cap_data_q[4]) begin
          end else if (cap_data_q[3]) begin
            disp_d   = cap_data_q[2];
            cursor_d = cap_data_q[1];
            blink_d  = cap_data_q[0];
          end else if (cap_data_q[2]) begin
            incr_d = cap_data_q[1];
          end else if (cap_data_q[1]) begin
            ac_d = 7'h00;
          end else if (cap_data_q[0]) begin
            state_d   = CLEAR;
            clr_cnt_d = LAST_IDX;
          end
        end
      end
      CLEAR: begin
        we = 1'b1;
        if (clr_cnt_q == 7'd0) begin
          state_d = IDLE;
          ac_d    = 7'h00;
          incr_d  = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q - 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // One-line mode can address past the array after an out-of-range AC set.
    if (wa > LAST_IDX) we = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= LAST_IDX;
      ac_q       <= 7'h00;
      cap_rs_q   <= 1'b0;
      cap_data_q <= '0;
      last_q     <= '0;
      disp_q     <= 1'b0;
      cursor_q   <= 1'b0;
      blink_q    <= 1'b0;
      incr_q     <= 1'b1;
      two_line_q <= 1'b0;
      rw_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      ac_q       <= ac_d;
      cap_rs_q   <= cap_rs_d;
      cap_data_q <= cap_data_d;
      last_q     <= last_d;
      disp_q     <= disp_d;
      cursor_q   <= cursor_d;
      blink_q    <= blink_d;
      incr_q     <= incr_d;
      two_line_q <= two_line_d;
      rw_err_q   <= rw_err_d;
    end
  end

  logic [DATA_BITS-1:0] ram_q [DEPTH];
  logic [DATA_BITS-1:0] rd_char_q;
  logic [6:0]           rd_idx;

  assign rd_idx = {{(7-COL_W){1'b0}}, rd_col} + (rd_line ? LINE_LEN7 : 7'd0);

  always_ff @(posedge clk) begin
    if (we) ram_q[wa] <= wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_char_q <= '0;
    else        rd_char_q <= ram_q[rd_idx];
  end

  assign rd_char   = rd_char_q;
  assign addr_ctr  = ac_q;
  assign busy      = (state_q == CLEAR);
  assign last_byte = last_q;
  assign disp_on   = disp_q;
  assign cursor_on = cursor_q;
  assign blink_on  = blink_q;
  assign incr_mode = incr_q;
  assign two_line  = two_line_q;
  assign rw_error  = rw_err_q;

endmodule
